// File: rtl/camera_orbit_sequencer_pkg.sv
// Shared types and default constants for the orbit-camera sequencer and its
// orbit state register.
package camera_pkg;

  localparam int DEF_ANGLE_WIDTH  = 8;
  localparam int DEF_SINCOS_WIDTH = 16;
  localparam int DEF_POS_WIDTH    = 18;
  localparam int DEF_FRAC         = 14;
  localparam int DEF_THETA_MIN    = 8;
  localparam int DEF_THETA_MAX    = 120;
  localparam int DEF_THETA_RESET  = 64;
  localparam int DEF_PHI_RESET    = 0;
  localparam int DEF_CAM_LATENCY  = 5;

  localparam logic [DEF_POS_WIDTH-1:0] DEF_MAG_MIN   = 18'h04000;
  localparam logic [DEF_POS_WIDTH-1:0] DEF_MAG_MAX   = 18'h1C000;
  localparam logic [DEF_POS_WIDTH-1:0] DEF_MAG_STEP  = 18'h00800;
  localparam logic [DEF_POS_WIDTH-1:0] DEF_MAG_RESET = 18'h0C000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_T  = 3'd1,
    ST_WAIT_T = 3'd2,
    ST_REQ_P  = 3'd3,
    ST_WAIT_P = 3'd4,
    ST_ISSUE  = 3'd5,
    ST_SETTLE = 3'd6
  } state_t;

  typedef struct packed {
    logic signed [DEF_SINCOS_WIDTH-1:0] sin_v;
    logic signed [DEF_SINCOS_WIDTH-1:0] cos_v;
  } sincos_pair_t;

endpackage

// File: rtl/camera_orbit_sequencer_orbit_state_reg.sv
// Live orbit state: theta saturates, phi wraps, magnitude clamps; dirty marks
// any real change since the last accepted update.
module orbit_state_reg
  import camera_pkg::*;
#(
  parameter int                     ANGLE_WIDTH = DEF_ANGLE_WIDTH,
  parameter int                     POS_WIDTH   = DEF_POS_WIDTH,
  parameter int                     THETA_MIN   = DEF_THETA_MIN,
  parameter int                     THETA_MAX   = DEF_THETA_MAX,
  parameter int                     THETA_RESET = DEF_THETA_RESET,
  parameter int                     PHI_RESET   = DEF_PHI_RESET,
  parameter logic [POS_WIDTH-1:0]   MAG_MIN     = DEF_MAG_MIN,
  parameter logic [POS_WIDTH-1:0]   MAG_MAX     = DEF_MAG_MAX,
  parameter logic [POS_WIDTH-1:0]   MAG_STEP    = DEF_MAG_STEP,
  parameter logic [POS_WIDTH-1:0]   MAG_RESET   = DEF_MAG_RESET
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   theta_inc,
  input  logic                   theta_dec,
  input  logic                   phi_inc,
  input  logic                   phi_dec,
  input  logic                   zoom_in,
  input  logic                   zoom_out,
  input  logic                   clear_dirty,
  output logic [ANGLE_WIDTH-1:0] theta,
  output logic [ANGLE_WIDTH-1:0] phi,
  output logic [POS_WIDTH-1:0]   mag,
  output logic                   dirty
);

  localparam logic [ANGLE_WIDTH-1:0] THETA_LO = ANGLE_WIDTH'(THETA_MIN);
  localparam logic [ANGLE_WIDTH-1:0] THETA_HI = ANGLE_WIDTH'(THETA_MAX);

  logic [ANGLE_WIDTH-1:0] theta_d;
  logic [ANGLE_WIDTH-1:0] phi_d;
  logic [POS_WIDTH-1:0]   mag_d;
  logic [POS_WIDTH:0]     mag_ext;
  logic                   changed;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    theta_d = theta;
    if (theta_inc && !theta_dec && theta < THETA_HI) theta_d = theta + 1'b1;
    if (theta_dec && !theta_inc && theta > THETA_LO) theta_d = theta - 1'b1;

    phi_d = phi;
    if (phi_inc && !phi_dec) phi_d = phi + 1'b1;
    if (phi_dec && !phi_inc) phi_d = phi - 1'b1;

    mag_ext = {1'b0, mag};
    if (zoom_out && !zoom_in) begin
      mag_ext = {1'b0, mag} + {1'b0, MAG_STEP};
      if (mag_ext > {1'b0, MAG_MAX}) mag_ext = {1'b0, MAG_MAX};
    end else if (zoom_in && !zoom_out) begin
      mag_ext = {1'b0, mag} - {1'b0, MAG_STEP};
      // A borrow lands in the extra top bit, which also means below the floor.
      if (mag_ext[POS_WIDTH] || mag_ext < {1'b0, MAG_MIN}) mag_ext = {1'b0, MAG_MIN};
    end
    mag_d = mag_ext[POS_WIDTH-1:0];

    changed = (theta_d != theta) || (phi_d != phi) || (mag_d != mag);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      theta <= ANGLE_WIDTH'(THETA_RESET);
      phi   <= ANGLE_WIDTH'(PHI_RESET);
      mag   <= MAG_RESET;
      dirty <= 1'b1;
    end else begin
      theta <= theta_d;
      phi   <= phi_d;
      mag   <= mag_d;
      // A change in the same cycle as an accepted update must survive the clear.
      if (changed)          dirty <= 1'b1;
      else if (clear_dirty) dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/camera_orbit_sequencer.sv
// Orbit-camera sequencer: snapshots the orbit state, runs two shared sin/cos
// lookups, issues one valid to the camera block and waits out its latency.
module camera_orbit_sequencer
  import camera_pkg::*;
#(
  parameter int                   ANGLE_WIDTH  = DEF_ANGLE_WIDTH,
  parameter int                   SINCOS_WIDTH = DEF_SINCOS_WIDTH,
  parameter int                   POS_WIDTH    = DEF_POS_WIDTH,
  parameter int                   FRAC         = DEF_FRAC,
  parameter int                   THETA_MIN    = DEF_THETA_MIN,
  parameter int                   THETA_MAX    = DEF_THETA_MAX,
  parameter logic [POS_WIDTH-1:0] MAG_MIN      = POS_WIDTH'(1) << FRAC,
  parameter logic [POS_WIDTH-1:0] MAG_MAX      = POS_WIDTH'(7) << FRAC,
  parameter logic [POS_WIDTH-1:0] MAG_STEP     = POS_WIDTH'(1) << (FRAC - 3),
  parameter int                   THETA_RESET  = DEF_THETA_RESET,
  parameter int                   PHI_RESET    = DEF_PHI_RESET,
  parameter logic [POS_WIDTH-1:0] MAG_RESET    = POS_WIDTH'(3) << FRAC,
  parameter int                   CAM_LATENCY  = DEF_CAM_LATENCY
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           theta_inc_in,
  input  logic                           theta_dec_in,
  input  logic                           phi_inc_in,
  input  logic                           phi_dec_in,
  input  logic                           zoom_in_in,
  input  logic                           zoom_out_in,
  input  logic                           frame_start_in,
  output logic                           sincos_req_out,
  output logic [ANGLE_WIDTH-1:0]         sincos_angle_out,
  input  logic                           sincos_valid_in,
  input  logic signed [SINCOS_WIDTH-1:0] sin_in,
  input  logic signed [SINCOS_WIDTH-1:0] cos_in,
  output logic                           cam_valid_out,
  output logic signed [SINCOS_WIDTH-1:0] cam_sin_theta_out,
  output logic signed [SINCOS_WIDTH-1:0] cam_cos_theta_out,
  output logic signed [SINCOS_WIDTH-1:0] cam_sin_phi_out,
  output logic signed [SINCOS_WIDTH-1:0] cam_cos_phi_out,
  output logic [POS_WIDTH-1:0]           cam_mag_out,
  output logic                           busy_out,
  output logic                           basis_ready_out,
  output logic [ANGLE_WIDTH-1:0]         theta_out,
  output logic [ANGLE_WIDTH-1:0]         phi_out
);

  localparam int CNT_W = $clog2(CAM_LATENCY + 1);

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ANGLE_WIDTH-1:0] snap_theta_q;
  logic [ANGLE_WIDTH-1:0] snap_phi_q;
  logic [POS_WIDTH-1:0]   snap_mag_q;
  sincos_pair_t           theta_pair_q;
  logic [POS_WIDTH-1:0]   mag;
  logic                   dirty;
  logic                   accept;

  assign accept = (state_q == ST_IDLE) && frame_start_in && dirty;

  orbit_state_reg #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .POS_WIDTH   (POS_WIDTH),
    .THETA_MIN   (THETA_MIN),
    .THETA_MAX   (THETA_MAX),
    .THETA_RESET (THETA_RESET),
    .PHI_RESET   (PHI_RESET),
    .MAG_MIN     (MAG_MIN),
    .MAG_MAX     (MAG_MAX),
    .MAG_STEP    (MAG_STEP),
    .MAG_RESET   (MAG_RESET)
  ) u_state (
    .clk         (clk_in),
    .rst         (rst_in),
    .theta_inc   (theta_inc_in),
    .theta_dec   (theta_dec_in),
    .phi_inc     (phi_inc_in),
    .phi_dec     (phi_dec_in),
    .zoom_in     (zoom_in_in),
    .zoom_out    (zoom_out_in),
    .clear_dirty (accept),
    .theta       (theta_out),
    .phi         (phi_out),
    .mag         (mag),
    .dirty       (dirty)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      snap_theta_q      <= '0;
      snap_phi_q        <= '0;
      snap_mag_q        <= '0;
      theta_pair_q      <= '0;
      sincos_req_out    <= 1'b0;
      sincos_angle_out  <= '0;
      cam_sin_theta_out <= '0;
      cam_cos_theta_out <= '0;
      cam_sin_phi_out   <= '0;
      cam_cos_phi_out   <= '0;
      cam_mag_out       <= '0;
    end else begin
      sincos_req_out <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            snap_theta_q <= theta_out;
            snap_phi_q   <= phi_out;
            snap_mag_q   <= mag;
            state_q      <= ST_REQ_T;
          end
        end
        ST_REQ_T: begin
          sincos_req_out   <= 1'b1;
          sincos_angle_out <= snap_theta_q;
          state_q          <= ST_WAIT_T;
        end
        ST_WAIT_T: begin
          // Theta is staged so the cam_* outputs only move together at ISSUE.
          if (sincos_valid_in) begin
            theta_pair_q <= '{sin_v: sin_in, cos_v: cos_in};
            state_q      <= ST_REQ_P;
          end
        end
        ST_REQ_P: begin
          sincos_req_out   <= 1'b1;
          sincos_angle_out <= snap_phi_q;
          state_q          <= ST_WAIT_P;
        end
        ST_WAIT_P: begin
          if (sincos_valid_in) begin
            cam_sin_theta_out <= theta_pair_q.sin_v;
            cam_cos_theta_out <= theta_pair_q.cos_v;
            cam_sin_phi_out   <= sin_in;
            cam_cos_phi_out   <= cos_in;
            cam_mag_out       <= snap_mag_q;
            state_q           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= CNT_W'(CAM_LATENCY);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cam_valid_out   = (state_q == ST_ISSUE);
  assign basis_ready_out = (state_q == ST_SETTLE) && (cnt_q == '0);
  assign busy_out        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_camera_orbit_sequencer.sv
// Scoreboard bench for camera_orbit_sequencer with a fixed-latency sin/cos model.
module tb_camera_orbit_sequencer;

  localparam int L        = 3;
  localparam int VALID_AT = 2 * L + 5;
  localparam int READY_AT = 2 * L + 5 + 6;

  localparam logic [6:0] TI = 7'h01;
  localparam logic [6:0] TD = 7'h02;
  localparam logic [6:0] PI = 7'h04;
  localparam logic [6:0] PD = 7'h08;
  localparam logic [6:0] ZO = 7'h10;
  localparam logic [6:0] ZI = 7'h20;
  localparam logic [6:0] FS = 7'h40;

  typedef struct {
    logic [15:0] st;
    logic [15:0] ct;
    logic [15:0] sp;
    logic [15:0] cp;
    logic [17:0] mag;
    int          cyc;
  } cam_exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        theta_inc_in = 1'b0, theta_dec_in = 1'b0;
  logic        phi_inc_in = 1'b0, phi_dec_in = 1'b0;
  logic        zoom_in_in = 1'b0, zoom_out_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        sincos_valid_in = 1'b0;
  logic [15:0] sin_in = 16'hDEAD, cos_in = 16'hBEEF;
  logic        sincos_req_out, cam_valid_out, busy_out, basis_ready_out;
  logic [7:0]  sincos_angle_out, theta_out, phi_out;
  logic [15:0] cam_sin_theta_out, cam_cos_theta_out, cam_sin_phi_out, cam_cos_phi_out;
  logic [17:0] cam_mag_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_count = 0;
  int model_cd = 0;
  logic [7:0] model_angle = '0;
  logic stray = 1'b0;

  logic [7:0] angle_q[$];
  cam_exp_t   cam_q[$];
  int         ready_q[$];

  camera_orbit_sequencer dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .theta_inc_in      (theta_inc_in),
    .theta_dec_in      (theta_dec_in),
    .phi_inc_in        (phi_inc_in),
    .phi_dec_in        (phi_dec_in),
    .zoom_in_in        (zoom_in_in),
    .zoom_out_in       (zoom_out_in),
    .frame_start_in    (frame_start_in),
    .sincos_req_out    (sincos_req_out),
    .sincos_angle_out  (sincos_angle_out),
    .sincos_valid_in   (sincos_valid_in),
    .sin_in            (sin_in),
    .cos_in            (cos_in),
    .cam_valid_out     (cam_valid_out),
    .cam_sin_theta_out (cam_sin_theta_out),
    .cam_cos_theta_out (cam_cos_theta_out),
    .cam_sin_phi_out   (cam_sin_phi_out),
    .cam_cos_phi_out   (cam_cos_phi_out),
    .cam_mag_out       (cam_mag_out),
    .busy_out          (busy_out),
    .basis_ready_out   (basis_ready_out),
    .theta_out         (theta_out),
    .phi_out           (phi_out)
  );

  initial forever #5 clk_in = ~clk_in;
  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  function automatic logic [15:0] sin_of(input logic [7:0] a);
    return 16'h2000 ^ {8'h00, a};
  endfunction

  function automatic logic [15:0] cos_of(input logic [7:0] a);
    return 16'h376D ^ {a, 8'h00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lookup model: answers each request L cycles later.
  initial forever begin
    @(negedge clk_in);
    sincos_valid_in = 1'b0;
    sin_in = 16'hDEAD;
    cos_in = 16'hBEEF;
    if (stray) begin
      sincos_valid_in = 1'b1;
      sin_in = 16'h7FFF;
      cos_in = 16'h7FFF;
      stray = 1'b0;
    end
    if (model_cd > 0) begin
      model_cd--;
      if (model_cd == 0) begin
        sincos_valid_in = 1'b1;
        sin_in = sin_of(model_angle);
        cos_in = cos_of(model_angle);
      end
    end
    if (sincos_req_out) begin
      model_cd = L;
      model_angle = sincos_angle_out;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial forever begin
    cam_exp_t e;
    @(negedge clk_in);
    if (sincos_req_out) begin
      if (angle_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: angle %0d, no request expected (cycle %0d)", sincos_angle_out, cyc);
      end else check("req_angle", {24'd0, sincos_angle_out}, {24'd0, angle_q.pop_front()});
    end
    if (cam_valid_out) begin
      if (cam_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_cam_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = cam_q.pop_front();
        check("cam_valid_cycle", cyc, e.cyc);
        check("cam_sin_theta", {16'd0, cam_sin_theta_out}, {16'd0, e.st});
        check("cam_cos_theta", {16'd0, cam_cos_theta_out}, {16'd0, e.ct});
        check("cam_sin_phi", {16'd0, cam_sin_phi_out}, {16'd0, e.sp});
        check("cam_cos_phi", {16'd0, cam_cos_phi_out}, {16'd0, e.cp});
        check("cam_mag", {14'd0, cam_mag_out}, {14'd0, e.mag});
      end
    end
    if (basis_ready_out) begin
      ready_count++;
      if (ready_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_basis_ready: got 1, expected 0 (cycle %0d)", cyc);
      end else check("basis_ready_cycle", cyc, ready_q.pop_front());
    end
  end

  task automatic drive(input logic [6:0] v);
    {frame_start_in, zoom_in_in, zoom_out_in, phi_dec_in, phi_inc_in, theta_dec_in, theta_inc_in} = v;
    @(negedge clk_in);
    {frame_start_in, zoom_in_in, zoom_out_in, phi_dec_in, phi_inc_in, theta_dec_in, theta_inc_in} = '0;
  endtask

  task automatic frame(input logic [7:0] th, input logic [7:0] ph, input logic [17:0] mg,
                       input bit with_ready);
    cam_exp_t e;
    angle_q.push_back(th);
    angle_q.push_back(ph);
    e.st = sin_of(th);
    e.ct = cos_of(th);
    e.sp = sin_of(ph);
    e.cp = cos_of(ph);
    e.mag = mg;
    e.cyc = cyc + VALID_AT;
    cam_q.push_back(e);
    if (with_ready) ready_q.push_back(cyc + READY_AT);
    drive(FS);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_reached", {31'd0, busy_out}, 32'd0);
  endtask

  task automatic quiet_frame(input string name);
    bit seen = 1'b0;
    drive(FS);
    repeat (15) begin
      if (busy_out) seen = 1'b1;
      @(negedge clk_in);
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;
    int rc;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    check("rst_theta", {24'd0, theta_out}, 32'd64);
    check("rst_phi", {24'd0, phi_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_req", {31'd0, sincos_req_out}, 32'd0);
    check("rst_cam_valid", {31'd0, cam_valid_out}, 32'd0);
    check("rst_ready", {31'd0, basis_ready_out}, 32'd0);
    check("rst_cam_mag", {14'd0, cam_mag_out}, 32'd0);
    check("rst_cam_sin_theta", {16'd0, cam_sin_theta_out}, 32'd0);

    // First update always runs after reset.
    frame(8'd64, 8'd0, 18'h0C000, 1'b1);
    wait_idle();
    quiet_frame("clean_frame_busy");

    // Phi wraps both ways; each step marks dirty.
    drive(PD);
    check("phi_wrap_dec", {24'd0, phi_out}, 32'd255);
    drive(PI);
    check("phi_wrap_inc", {24'd0, phi_out}, 32'd0);
    frame(8'd64, 8'd0, 18'h0C000, 1'b1);
    wait_idle();

    // Theta saturates at the top without marking dirty.
    repeat (56) drive(TI);
    check("theta_at_max", {24'd0, theta_out}, 32'd120);
    frame(8'd120, 8'd0, 18'h0C000, 1'b1);
    wait_idle();
    drive(TI);
    check("theta_saturated", {24'd0, theta_out}, 32'd120);
    quiet_frame("theta_sat_busy");

    // Magnitude clamps at the ceiling; opposing pulses do nothing.
    repeat (40) drive(ZO);
    frame(8'd120, 8'd0, 18'h1C000, 1'b1);
    wait_idle();
    drive(ZI | ZO | TI | TD | PI | PD);
    check("opposing_theta", {24'd0, theta_out}, 32'd120);
    check("opposing_phi", {24'd0, phi_out}, 32'd0);
    quiet_frame("opposing_busy");
    drive(ZI);
    frame(8'd120, 8'd0, 18'h1B800, 1'b1);
    wait_idle();

    // Input change and trigger while waiting on the theta lookup.
    drive(PI);
    f = cyc;
    frame(8'd120, 8'd1, 18'h1B800, 1'b1);
    while (cyc < f + 3) @(negedge clk_in);
    drive(PI | FS);
    wait_idle();
    check("phi_live_during_busy", {24'd0, phi_out}, 32'd2);
    frame(8'd120, 8'd2, 18'h1B800, 1'b1);
    wait_idle();

    // Reset during SETTLE aborts without a ready pulse.
    drive(PD);
    f = cyc;
    frame(8'd120, 8'd1, 18'h1B800, 1'b0);
    while (cyc < f + 13) @(negedge clk_in);
    check("in_settle_busy", {31'd0, busy_out}, 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("abort_busy", {31'd0, busy_out}, 32'd0);
    check("abort_cam_mag", {14'd0, cam_mag_out}, 32'd0);
    check("abort_cam_cos_phi", {16'd0, cam_cos_phi_out}, 32'd0);
    check("abort_theta", {24'd0, theta_out}, 32'd64);
    rc = ready_count;
    stray = 1'b1;
    repeat (10) @(negedge clk_in);
    check("abort_no_ready", rc, ready_count);
    check("stray_valid_busy", {31'd0, busy_out}, 32'd0);
    check("stray_valid_cam_sin", {16'd0, cam_sin_theta_out}, 32'd0);
    frame(8'd64, 8'd0, 18'h0C000, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk_in);
    check("pending_req_left", angle_q.size(), 0);
    check("pending_cam_left", cam_q.size(), 0);
    check("pending_ready_left", ready_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
